fetch_decode_seq: RTL and testbench
===================================

// Module: fetch_decode_seq
// PURPOSE
//  Single-clock instruction fetch/decode sequencer for the core. It replaces the CLK1/CLK2 pair with a
//  FETCH/EXEC state machine on one clock. It owns the PC, the boot address and the instruction register.
//  Decoded fields are generated from the registered instruction.
//  Sits between the instruction ROM (combinational, addr_o -> ins_i) and core; exec_en qualifies core writes.
// PARAMETERS
//  ADDR_W       8   PC / ROM address width
//  DATA_W       8   datapath width; also IMM field width
//  OP_W         4   ALU/branch opcode field width
//  RSEL_W       3   register-select field width (TGT, AS, BS)
//  CNT_W        16  retired-instruction counter width
//  BOOT_ADDR    0   PC value loaded by reset
//  HALT_ON_ZERO 1   1: all-zero instruction halts the sequencer after it executes
//  INS_W  (localparam) = 3+OP_W+2*RSEL_W+DATA_W (21 at defaults)
// PORTS
//  CLK           in   1       system clock, all state updates on posedge
//  reset         in   1       synchronous, active-high
//  stall         in   1       1 = hold current state, PC, IR and counter
//  run           in   1       leave HALT (sampled only in HALT)
//  ins_i         in   INS_W   instruction from ROM at addr_o (same-cycle)
//  branch_taken  in   1       core branch decision, valid while exec_en=1
//  branch_target in   ADDR_W  jump destination, valid with branch_taken
//  addr_o        out  ADDR_W  registered PC
//  exec_en       out  1       core capture/write strobe
//  alu_inst, mem_inst, jmp_inst  out 1 each  instruction class
//  ms            out  2       regbank mode select {MS1,MS0}
//  irs           out  1       immediate/register select for ALU B
//  op            out  OP_W    opcode field
//  tgt, as_sel, bs_sel  out RSEL_W each  target, A-mux and B-mux selects
//  imm           out  DATA_W  immediate field
//  halted        out  1       1 while in HALT
//  retired       out  CNT_W   count of executed instructions
// BEHAVIOUR
//  States: FETCH, EXEC, HALT. Reset (dominates stall/run) forces these values:
//    state=FETCH, PC=BOOT_ADDR, IR=0, retired=0, halted=0, exec_en=0.
//  Field map of IR, MSB first: [INSTYPE 2][IRS 1][OP OP_W][TGT][AS][IMM DATA_W].
//    bs_sel = IMM[DATA_W-1 -: RSEL_W] (overlaps IMM).
//  Decode is combinational from IR, so all fields are 0 after reset:
//    alu_inst=T1, mem_inst=T0, jmp_inst=~(T1|T0)
//    MS1=(T1^IRS)&~(T1&T0), MS0=(T0^IRS)&~(T1&T0)   (T1,T0 = INSTYPE bits)
//  FETCH: addr_o=PC. At the next non-stalled edge: IR<=ins_i, go to EXEC. exec_en=0.
//  EXEC: exec_en=(state==EXEC)&~stall, combinational. At the non-stalled edge:
//    PC <= (jmp_inst & branch_taken) ? branch_target : PC+1, mod 2^ADDR_W (wraps to 0).
//    branch_taken is ignored for non-jump instructions.
//    retired <= retired+1, saturating at 2^CNT_W-1.
//    Next state is HALT if HALT_ON_ZERO & IR==0, else FETCH.
//  HALT: halted=1, exec_en=0, PC/IR hold. run=1 at an edge -> FETCH (fetches the updated PC); stall ignored.
//  stall=1 in FETCH/EXEC: every register holds and exec_en=0. Released stall resumes the same phase.
//  Throughput: 1 instruction per 2 un-stalled cycles. ins_i to exec_en latency is 1 cycle.
//  Reset asserted mid-EXEC: no PC/counter update that edge; reset values apply next cycle.
// TESTING
//  1 Reset, ROM[0]=MOV R0,#5 (011000000000000000101), ROM[1]=MOV R1,#7, no stall:
//    cycle1 exec_en=1, ms=2'b10, tgt=0, imm=5; addr_o=1 at cycle2; retired=2 after 4 cycles.
//  2 ROM[2]=JE-class jmp, imm=64, branch_taken=1, target=64: addr_o=64 next FETCH.
//    Same with branch_taken=0: addr_o=3. Non-jmp ALU instr with branch_taken=1: addr_o=PC+1.
//  3 stall=1 for 3 cycles during EXEC: exec_en=0, addr_o/retired frozen.
//    Release: exec_en=1 for one cycle, then normal.
//  4 ROM[5]=0, HALT_ON_ZERO=1: after its EXEC, halted=1, addr_o=6, exec_en stays 0 for 10 cycles;
//    run pulse -> FETCH at 6, halted=0.
//  5 PC=255 (ADDR_W=8), non-jump instr executes: addr_o wraps to 0.
//    CNT_W=2 after 5 retires: retired=3.
//  6 reset asserted during EXEC of instr at PC=9: next cycle addr_o=BOOT_ADDR,
//    retired=0, IR fields 0, exec_en=0.

Source files
------------

// File: rtl/fetch_decode_seq.sv
// Single-clock fetch/decode sequencer.
// - Cycles through FETCH, EXEC and HALT states.
// - Owns the PC, the instruction register and the retired-instruction counter.
// - Decodes instruction fields combinationally from the registered instruction.
// - exec_en qualifies core writes during the un-stalled EXEC cycle.
module fetch_decode_seq #(
  parameter int          ADDR_W       = 8,
  parameter int          DATA_W       = 8,
  parameter int          OP_W         = 4,
  parameter int          RSEL_W       = 3,
  parameter int          CNT_W        = 16,
  parameter int unsigned BOOT_ADDR    = 0,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic                                   CLK,
  input  logic                                   reset,
  input  logic                                   stall,
  input  logic                                   run,
  input  logic [3+OP_W+2*RSEL_W+DATA_W-1:0]      ins_i,
  input  logic                                   branch_taken,
  input  logic [ADDR_W-1:0]                      branch_target,
  output logic [ADDR_W-1:0]                      addr_o,
  output logic                                   exec_en,
  output logic                                   alu_inst,
  output logic                                   mem_inst,
  output logic                                   jmp_inst,
  output logic [1:0]                             ms,
  output logic                                   irs,
  output logic [OP_W-1:0]                        op,
  output logic [RSEL_W-1:0]                      tgt,
  output logic [RSEL_W-1:0]                      as_sel,
  output logic [RSEL_W-1:0]                      bs_sel,
  output logic [DATA_W-1:0]                      imm,
  output logic                                   halted,
  output logic [CNT_W-1:0]                       retired
);

  // Instruction word: [INSTYPE 2][IRS 1][OP][TGT][AS][IMM], MSB first.
  localparam int INS_W   = 3 + OP_W + 2*RSEL_W + DATA_W;
  localparam int TGT_MSB = DATA_W + 2*RSEL_W - 1;
  localparam int AS_MSB  = DATA_W + RSEL_W - 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [INS_W-1:0]    ir;
  logic [CNT_W-1:0]    retired_q;
  logic                halted_q;
  logic                t1;
  logic                t0;
  logic                is_jmp;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Next PC: branch target only for jump-class instructions, else sequential with wrap.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] cur,
                                                input logic              jmp,
                                                input logic              taken,
                                                input logic [ADDR_W-1:0] dest);
    if (jmp && taken) begin
      return dest;
    end
    return cur + ADDR_W'(1);
  endfunction

  // Decode fields straight from the instruction register.
  assign t1       = ir[INS_W-1];
  assign t0       = ir[INS_W-2];
  assign irs      = ir[INS_W-3];
  assign op       = ir[INS_W-4 -: OP_W];
  assign tgt      = ir[TGT_MSB -: RSEL_W];
  assign as_sel   = ir[AS_MSB -: RSEL_W];
  assign imm      = ir[DATA_W-1:0];
  assign bs_sel   = ir[DATA_W-1 -: RSEL_W];
  assign alu_inst = t1;
  assign mem_inst = t0;
  assign is_jmp   = ~(t1 | t0);
  assign jmp_inst = is_jmp;
  assign ms       = {(t1 ^ irs) & ~(t1 & t0), (t0 ^ irs) & ~(t1 & t0)};

  assign addr_o   = pc;
  assign retired  = retired_q;
  assign halted   = halted_q;
  // Write strobe drops immediately on stall so the core never captures twice.
  assign exec_en  = (state == S_EXEC) & ~stall;

  // Sequencer: state, PC, IR, retired counter and halt flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= ADDR_W'(BOOT_ADDR);
      ir        <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!stall) begin
            ir    <= ins_i;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            pc        <= next_pc(pc, is_jmp, branch_taken, branch_target);
            retired_q <= sat_inc(retired_q);
            if (HALT_ON_ZERO && (ir == '0)) begin
              state    <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          // stall has no effect here; only run releases the sequencer.
          if (run) begin
            state    <= S_FETCH;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state    <= S_FETCH;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_seq.sv
// Directed bench for fetch_decode_seq: a ROM program walked through by a vector table,
// with hand sequences for stall, halt/run, wrap, counter saturation and reset mid-EXEC.
module tb_fetch_decode_seq;

  logic        CLK;
  logic        reset;
  logic        stall;
  logic        run;
  logic [20:0] ins_i;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  addr_o;
  logic        exec_en, alu_inst, mem_inst, jmp_inst, irs, halted;
  logic [1:0]  ms;
  logic [3:0]  op;
  logic [2:0]  tgt, as_sel, bs_sel;
  logic [7:0]  imm;
  logic [15:0] retired;

  // Second instance with a 2-bit counter to observe saturation.
  logic [20:0] ins_c;
  logic [7:0]  addr_c;
  logic        exec_c, alu_c, mem_c, jmp_c, irs_c, halted_c;
  logic [1:0]  ms_c;
  logic [3:0]  op_c;
  logic [2:0]  tgt_c, as_c, bs_c;
  logic [7:0]  imm_c;
  logic [1:0]  retired_c;

  logic [20:0] rom [256];

  int n_vec = 0;
  int n_bad = 0;

  fetch_decode_seq dut (
    .CLK(CLK), .reset(reset), .stall(stall), .run(run), .ins_i(ins_i),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .addr_o(addr_o), .exec_en(exec_en), .alu_inst(alu_inst), .mem_inst(mem_inst),
    .jmp_inst(jmp_inst), .ms(ms), .irs(irs), .op(op), .tgt(tgt), .as_sel(as_sel),
    .bs_sel(bs_sel), .imm(imm), .halted(halted), .retired(retired)
  );

  fetch_decode_seq #(.CNT_W(2)) dut_c (
    .CLK(CLK), .reset(reset), .stall(stall), .run(run), .ins_i(ins_c),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .addr_o(addr_c), .exec_en(exec_c), .alu_inst(alu_c), .mem_inst(mem_c),
    .jmp_inst(jmp_c), .ms(ms_c), .irs(irs_c), .op(op_c), .tgt(tgt_c), .as_sel(as_c),
    .bs_sel(bs_c), .imm(imm_c), .halted(halted_c), .retired(retired_c)
  );

  assign ins_i = rom[addr_o];
  assign ins_c = rom[addr_c];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [7:0]  pc;
    logic        bt;
    logic [7:0]  btgt;
    logic [20:0] ins;
    logic        alu, mem, jmp;
    logic [1:0]  ms;
    logic        irs;
    logic [3:0]  op;
    logic [2:0]  tgt, as_s, bs;
    logic [7:0]  imm;
    int          ret;
  } row_t;

  row_t tbl [15];

  function automatic logic [20:0] enc(input logic [1:0] ty, input logic i,
                                      input logic [3:0] o, input logic [2:0] t,
                                      input logic [2:0] a, input logic [7:0] m);
    return {ty, i, o, t, a, m};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Walk rows lo..hi: one FETCH cycle and one EXEC cycle each.
  task automatic run_rows(input int lo, input int hi);
    row_t r;
    for (int i = lo; i <= hi; i++) begin
      r = tbl[i];
      branch_taken  = 1'b0;
      branch_target = 8'h00;
      #2;
      chk($sformatf("row%0d fetch addr", i), 32'(addr_o), 32'(r.pc));
      chk($sformatf("row%0d fetch exec_en", i), 32'(exec_en), 32'd0);
      chk($sformatf("row%0d fetch halted", i), 32'(halted), 32'd0);
      tick();
      branch_taken  = r.bt;
      branch_target = r.btgt;
      #2;
      chk($sformatf("row%0d exec_en", i), 32'(exec_en), 32'd1);
      chk($sformatf("row%0d exec addr", i), 32'(addr_o), 32'(r.pc));
      chk($sformatf("row%0d class", i), 32'({alu_inst, mem_inst, jmp_inst}),
          32'({r.alu, r.mem, r.jmp}));
      chk($sformatf("row%0d ms", i), 32'(ms), 32'(r.ms));
      chk($sformatf("row%0d irs/op", i), 32'({irs, op}), 32'({r.irs, r.op}));
      chk($sformatf("row%0d tgt/as/bs", i), 32'({tgt, as_sel, bs_sel}),
          32'({r.tgt, r.as_s, r.bs}));
      chk($sformatf("row%0d imm", i), 32'(imm), 32'(r.imm));
      chk($sformatf("row%0d retired", i), 32'(retired), r.ret);
      chk($sformatf("row%0d retired_c", i), 32'(retired_c), (r.ret > 3) ? 3 : r.ret);
      tick();
    end
    branch_taken  = 1'b0;
    branch_target = 8'h00;
  endtask

  initial begin
    //            pc     bt    btgt   ins                                         alu   mem   jmp   ms     irs   op    tgt   as    bs    imm    ret
    tbl[0]  = '{8'd0,   1'b0, 8'h00, 21'b011000000000000000101,                  1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 4'h0, 3'd0, 3'd0, 3'd0, 8'h05, 0};
    tbl[1]  = '{8'd1,   1'b0, 8'h00, enc(2'b01, 1'b1, 4'h0, 3'd1, 3'd0, 8'h07), 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 4'h0, 3'd1, 3'd0, 3'd0, 8'h07, 1};
    tbl[2]  = '{8'd2,   1'b1, 8'd64, enc(2'b00, 1'b0, 4'h3, 3'd0, 3'd0, 8'h40), 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h3, 3'd0, 3'd0, 3'd2, 8'h40, 2};
    tbl[3]  = '{8'd64,  1'b1, 8'h99, enc(2'b10, 1'b1, 4'h5, 3'd2, 3'd1, 8'h20), 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 4'h5, 3'd2, 3'd1, 3'd1, 8'h20, 3};
    tbl[4]  = '{8'd65,  1'b0, 8'hAA, enc(2'b00, 1'b1, 4'hA, 3'd0, 3'd0, 8'h11), 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 4'hA, 3'd0, 3'd0, 3'd0, 8'h11, 4};
    tbl[5]  = '{8'd67,  1'b1, 8'hFF, enc(2'b00, 1'b0, 4'h7, 3'd0, 3'd0, 8'hFF), 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h7, 3'd0, 3'd0, 3'd7, 8'hFF, 6};
    tbl[6]  = '{8'd255, 1'b1, 8'h10, enc(2'b11, 1'b1, 4'h9, 3'd5, 3'd6, 8'h5A), 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 4'h9, 3'd5, 3'd6, 3'd2, 8'h5A, 7};
    tbl[7]  = '{8'd0,   1'b0, 8'h00, 21'b011000000000000000101,                  1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 4'h0, 3'd0, 3'd0, 3'd0, 8'h05, 8};
    tbl[8]  = '{8'd1,   1'b0, 8'h00, enc(2'b01, 1'b1, 4'h0, 3'd1, 3'd0, 8'h07), 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 4'h0, 3'd1, 3'd0, 3'd0, 8'h07, 9};
    tbl[9]  = '{8'd2,   1'b0, 8'd64, enc(2'b00, 1'b0, 4'h3, 3'd0, 3'd0, 8'h40), 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h3, 3'd0, 3'd0, 3'd2, 8'h40, 10};
    tbl[10] = '{8'd3,   1'b0, 8'h00, enc(2'b11, 1'b1, 4'hC, 3'd7, 3'd7, 8'h80), 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 4'hC, 3'd7, 3'd7, 3'd4, 8'h80, 11};
    tbl[11] = '{8'd4,   1'b1, 8'h33, enc(2'b10, 1'b0, 4'h1, 3'd6, 3'd2, 8'h3C), 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 4'h1, 3'd6, 3'd2, 3'd1, 8'h3C, 12};
    tbl[12] = '{8'd6,   1'b0, 8'h00, enc(2'b01, 1'b0, 4'h6, 3'd3, 3'd5, 8'hA0), 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'h6, 3'd3, 3'd5, 3'd5, 8'hA0, 14};
    tbl[13] = '{8'd7,   1'b0, 8'h00, enc(2'b10, 1'b1, 4'hF, 3'd4, 3'd3, 8'h07), 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 4'hF, 3'd4, 3'd3, 3'd0, 8'h07, 15};
    tbl[14] = '{8'd8,   1'b0, 8'h00, enc(2'b01, 1'b1, 4'h8, 3'd2, 3'd2, 8'hFE), 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 4'h8, 3'd2, 3'd2, 3'd7, 8'hFE, 16};

    for (int a = 0; a < 256; a++) rom[a] = enc(2'b10, 1'b0, 4'h0, 3'd0, 3'd0, 8'h00);
    for (int i = 0; i < 15; i++) rom[tbl[i].pc] = tbl[i].ins;
    rom[66] = enc(2'b10, 1'b0, 4'h2, 3'd3, 3'd4, 8'hE1);
    rom[5]  = 21'd0;
    rom[9]  = enc(2'b10, 1'b0, 4'h2, 3'd1, 3'd1, 8'h01);

    reset = 1'b1; stall = 1'b0; run = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00;
    tick();
    tick();
    #2;
    chk("reset addr", 32'(addr_o), 32'd0);
    chk("reset exec_en", 32'(exec_en), 32'd0);
    chk("reset halted", 32'(halted), 32'd0);
    chk("reset retired", 32'(retired), 32'd0);
    chk("reset fields", 32'({ms, irs, op, tgt, as_sel, bs_sel, imm}), 32'd0);
    chk("reset class", 32'({alu_inst, mem_inst, jmp_inst}), 32'b001);
    reset = 1'b0;

    run_rows(0, 4);

    // EXEC of 66 held by a 3-cycle stall.
    #2;
    chk("stall fetch addr", 32'(addr_o), 32'd66);
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("stall%0d exec_en", k), 32'(exec_en), 32'd0);
      chk($sformatf("stall%0d addr", k), 32'(addr_o), 32'd66);
      chk($sformatf("stall%0d retired", k), 32'(retired), 32'd5);
      tick();
    end
    stall = 1'b0;
    #2;
    chk("stall release exec_en", 32'(exec_en), 32'd1);
    chk("stall release imm/bs", 32'({imm, bs_sel}), 32'({8'hE1, 3'd7}));
    chk("stall release retired", 32'(retired), 32'd5);
    tick();

    run_rows(5, 11);

    // Zero instruction at 5 halts after it executes.
    #2;
    chk("halt fetch addr", 32'(addr_o), 32'd5);
    tick();
    #2;
    chk("zero exec_en", 32'(exec_en), 32'd1);
    chk("zero class", 32'({alu_inst, mem_inst, jmp_inst, imm}), 32'({3'b001, 8'h00}));
    tick();
    for (int k = 0; k < 10; k++) begin
      stall = k[0];
      #2;
      chk($sformatf("halt%0d halted", k), 32'(halted), 32'd1);
      chk($sformatf("halt%0d exec_en", k), 32'(exec_en), 32'd0);
      chk($sformatf("halt%0d addr", k), 32'(addr_o), 32'd6);
      chk($sformatf("halt%0d retired", k), 32'(retired), 32'd14);
      chk($sformatf("halt%0d sat", k), 32'({halted_c, retired_c}), 32'({1'b1, 2'd3}));
      tick();
    end
    run = 1'b1;
    stall = 1'b1;
    #2;
    chk("run pulse halted", 32'(halted), 32'd1);
    tick();
    run = 1'b0;
    stall = 1'b0;

    run_rows(12, 14);

    // Reset during EXEC of the instruction at 9.
    #2;
    chk("pc9 fetch addr", 32'(addr_o), 32'd9);
    tick();
    reset = 1'b1;
    #2;
    chk("pc9 exec_en", 32'(exec_en), 32'd1);
    tick();
    reset = 1'b0;
    #2;
    chk("post-reset addr", 32'(addr_o), 32'd0);
    chk("post-reset retired", 32'(retired), 32'd0);
    chk("post-reset retired_c", 32'(retired_c), 32'd0);
    chk("post-reset exec_en", 32'(exec_en), 32'd0);
    chk("post-reset fields", 32'({ms, tgt, imm, jmp_inst}), 32'd1);
    tick();
    #2;
    chk("cycle1 exec_en", 32'(exec_en), 32'd1);
    chk("cycle1 ms/tgt/imm", 32'({ms, tgt, imm}), 32'({2'b10, 3'd0, 8'd5}));
    tick();
    #2;
    chk("cycle2 addr", 32'(addr_o), 32'd1);
    tick();
    tick();
    #2;
    chk("retired after 4 cycles", 32'(retired), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
